mem_lsu: RTL and testbench

- Memory-stage load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address, plus the store-data operand, and runs one data-memory access over a valid/ready handshake.
- Returns sign/zero-extended load data or an alignment/bus-error exception.
- Asserts busy to stall the pipeline while an access is outstanding.

---
 rtl/mem_lsu_if.sv | 22 ++
 rtl/mem_lsu.sv | 175 +++++++++++++++++
 tb/tb_mem_lsu.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
interface mem_lsu_if #(
  parameter int n = 32
);
  logic         mem_req;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [3:0]   mem_be;
  logic [n-1:0] mem_wdata;
  logic         mem_ready;
  logic [n-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one data-memory access per request, with
// alignment checks, byte-lane steering, load extension and a ready timeout.
module mem_lsu #(
  parameter int n       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  input  logic [3:0]   ls_op,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  mem_lsu_if.master    mem,
  output logic         busy,
  output logic         resp_valid,
  output logic [n-1:0] load_data,
  output logic         exc_adel,
  output logic         exc_ades,
  output logic         bus_err
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  function automatic size_t op_size(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b1001: op_size = SZ_BYTE;
      4'b0011, 4'b0100, 4'b1011: op_size = SZ_HALF;
      4'b0101, 4'b1101:          op_size = SZ_WORD;
      default:                   op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] a);
    misaligned = (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a != 2'b00);
  endfunction

  function automatic logic [3:0] lane_be(input size_t sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: lane_be = 4'b0001 << a;
      SZ_HALF: lane_be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [n-1:0] lane_wdata(input size_t sz, input logic [n-1:0] d);
    case (sz)
      SZ_BYTE: lane_wdata = {4{d[7:0]}};
      SZ_HALF: lane_wdata = {2{d[15:0]}};
      SZ_WORD: lane_wdata = d;
      default: lane_wdata = '0;
    endcase
  endfunction

  function automatic logic [n-1:0] extend(input logic [3:0] op, input logic [1:0] a,
                                          input logic [n-1:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {a, 3'b000});
    h = 16'(rd >> {a[1], 4'b0000});
    case (op)
      4'b0001: extend = {{(n-8){b[7]}}, b};
      4'b0010: extend = {{(n-8){1'b0}}, b};
      4'b0011: extend = {{(n-16){h[15]}}, h};
      4'b0100: extend = {{(n-16){1'b0}}, h};
      4'b0101: extend = rd;
      default: extend = '0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [n-1:0]       addr_q, addr_d;
  logic [n-1:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [n-1:0]       ld_q, ld_d;
  logic               adel_q, adel_d;
  logic               ades_q, ades_d;

  size_t req_sz, lat_sz;
  logic  lat_store;
  assign req_sz    = op_size(ls_op);
  assign lat_sz    = op_size(op_q);
  assign lat_store = (lat_sz != SZ_NONE) && op_q[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      adel_q  <= 1'b0;
      ades_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      adel_q  <= adel_d;
      ades_q  <= ades_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ld_d    = ld_q;
    adel_d  = 1'b0;
    ades_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid && req_sz != SZ_NONE) begin
          // Misaligned requests never reach memory; they only raise a pulse.
          if (misaligned(req_sz, addr[1:0])) begin
            adel_d = !ls_op[3];
            ades_d = ls_op[3];
          end else begin
            op_d    = ls_op;
            addr_d  = addr;
            wdata_d = wdata;
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.mem_ready) begin
          if (!lat_store) ld_d = extend(op_q, addr_q[1:0], mem.mem_rdata);
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          if (!lat_store) ld_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are only driven during ACCESS so they read as zero otherwise.
  logic acc;
  assign acc           = (state_q == ACCESS);
  assign mem.mem_req   = acc;
  assign mem.mem_we    = acc && lat_store;
  assign mem.mem_addr  = acc ? {addr_q[n-1:2], 2'b00} : '0;
  assign mem.mem_be    = acc ? lane_be(lat_sz, addr_q[1:0]) : 4'b0000;
  assign mem.mem_wdata = (acc && lat_store) ? lane_wdata(lat_sz, wdata_q) : '0;

  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign bus_err    = resp_valid && err_q;
  assign load_data  = (resp_valid && lat_store) ? '0 : ld_q;
  assign exc_adel   = adel_q;
  assign exc_ades   = ades_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu against a byte-lane arithmetic model.
module tb_mem_lsu;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  ls_op = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, resp_valid, exc_adel, exc_ades, bus_err;
  logic [31:0] load_data;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [31:0] last_ld = '0;

  mem_lsu_if #(.n(32)) mif ();

  mem_lsu #(.n(32), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .ls_op      (ls_op),
    .addr       (addr),
    .wdata      (wdata),
    .mem        (mif),
    .busy       (busy),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .exc_adel   (exc_adel),
    .exc_ades   (exc_ades),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access width in bytes, 0 for a no-op code.
  function automatic int nbytes(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h9: return 1;
      4'h3, 4'h4, 4'hB: return 2;
      4'h5, 4'hD:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [3:0] op, input logic [31:0] a);
    int nb = nbytes(op);
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(input logic [3:0] op, input logic [31:0] wd);
    int nb = nbytes(op);
    if (!op[3]) return 32'h0;
    if (nb == 1) return wd[7:0] * 32'h0101_0101;
    if (nb == 2) return wd[15:0] * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_ld(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] rd);
    int nb = nbytes(op);
    logic [63:0] v;
    v = (64'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * nb)) - 64'd1);
    if ((op == 4'h1 || op == 4'h3) && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  // One aligned access; wt = number of not-ready ACCESS cycles (>= TIMEOUT never readies).
  task automatic do_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int wt, input bit junk);
    logic        is_st = op[3];
    logic        exp_err = (wt >= TIMEOUT);
    logic [31:0] exp_resp;
    bit          last;
    req_valid = 1'b1; ls_op = op; addr = a; wdata = wd;
    @(negedge clk);
    for (int k = 0; k < TIMEOUT; k++) begin
      chk("acc_mem_req", 32'(mif.mem_req), 32'd1);
      chk("acc_busy", 32'(busy), 32'd1);
      chk("acc_mem_addr", mif.mem_addr, a & 32'hFFFF_FFFC);
      chk("acc_mem_we", 32'(mif.mem_we), 32'(is_st));
      chk("acc_mem_be", 32'(mif.mem_be), 32'(m_be(op, a)));
      chk("acc_mem_wdata", mif.mem_wdata, m_wd(op, wd));
      chk("acc_resp_valid", 32'(resp_valid), 32'd0);
      if (k == 0) begin
        if (junk) begin
          ls_op = 4'($urandom_range(0, 15)); addr = $urandom; wdata = $urandom;
        end else begin
          req_valid = 1'b0;
        end
      end
      mif.mem_ready = (k == wt);
      mif.mem_rdata = (k == wt) ? rd : $urandom;
      last = (k == wt) || (k == TIMEOUT - 1);
      @(negedge clk);
      if (last) break;
    end
    mif.mem_ready = 1'b0;
    req_valid = 1'b0;
    if (is_st || exp_err) exp_resp = 32'h0;
    else exp_resp = m_ld(op, a, rd);
    if (!is_st) last_ld = exp_resp;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_bus_err", 32'(bus_err), 32'(exp_err));
    chk("resp_load_data", load_data, exp_resp);
    chk("resp_busy", 32'(busy), 32'd1);
    chk("resp_mem_req", 32'(mif.mem_req), 32'd0);
    @(negedge clk);
    chk("post_resp_valid", 32'(resp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_bus_err", 32'(bus_err), 32'd0);
    chk("post_load_data", load_data, last_ld);
  endtask

  task automatic do_misaligned(input logic [3:0] op, input logic [31:0] a);
    req_valid = 1'b1; ls_op = op; addr = a; wdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mis_exc_adel", 32'(exc_adel), 32'(!op[3]));
    chk("mis_exc_ades", 32'(exc_ades), 32'(op[3]));
    chk("mis_busy", 32'(busy), 32'd0);
    chk("mis_mem_req", 32'(mif.mem_req), 32'd0);
    chk("mis_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("mis_adel_clear", 32'(exc_adel), 32'd0);
    chk("mis_ades_clear", 32'(exc_ades), 32'd0);
    chk("mis_load_data", load_data, last_ld);
  endtask

  task automatic do_noop(input logic [3:0] op, input logic [31:0] a);
    req_valid = 1'b1; ls_op = op; addr = a; wdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    chk("noop_busy", 32'(busy), 32'd0);
    chk("noop_mem_req", 32'(mif.mem_req), 32'd0);
    chk("noop_exc", 32'({exc_adel, exc_ades}), 32'd0);
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("rst_mem_be", 32'(mif.mem_be), 32'd0);
    chk("rst_mem_addr", mif.mem_addr, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_exc", 32'({exc_adel, exc_ades, bus_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(4'h1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b0);   // LB
    chk("lb_value", last_ld, 32'hFFFF_FF80);
    do_access(4'h4, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 1'b0);   // LHU
    chk("lhu_value", last_ld, 32'h0000_BEEF);
    do_access(4'hB, 32'h0000_0040, 32'h1234_ABCD, 32'h0, 3, 1'b1);   // SH, 3 waits
    do_misaligned(4'h5, 32'h0000_0101);                              // LW
    do_misaligned(4'hB, 32'h0000_0003);                              // SH
    do_access(4'h5, 32'h0000_0000, 32'h0, 32'hDEAD_BEEF, 99, 1'b1);  // LW timeout
    do_access(4'h5, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 1'b1);
    chk("lw_late_value", last_ld, 32'hCAFE_F00D);

    // Asynchronous reset in the middle of an access.
    req_valid = 1'b1; ls_op = 4'h5; addr = 32'h0000_0080; wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_mem_req_before", 32'(mif.mem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_req", 32'(mif.mem_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_load_data", load_data, 32'd0);
    last_ld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_retry", 32'(mif.mem_req), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0]  op;
      logic [31:0] a;
      int          nb;
      int          wt;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      nb = nbytes(op);
      wt = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      if (nb == 0) do_noop(op, a);
      else if ((a % nb) != 0) do_misaligned(op, a);
      else do_access(op, a, $urandom, $urandom, wt, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
